// File: rtl/uart_device_core.sv
// uart_device_core: full-duplex UART device core, one serializer and one deserializer sharing
// one clock and a fixed clocks-per-bit divisor. No FIFOs: one byte in flight per direction.
//
// Optional feature macro: UART_PARITY_EN. Defined = one parity bit (even, or odd when
// PARITY_ODD = 1) follows the data bits and is checked on receive. Undefined = no parity bit,
// rx_parity_err is constant 0.
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   tx_data        byte to send, captured on the tx_valid & tx_ready handshake
//   tx_valid       send request
//   tx_ready       TX idle, can accept a byte
//   tx             serial output, idles high
//   rx             serial input, asynchronous to clk
//   rx_data        last received byte, held until the next rx_valid
//   rx_valid       one-cycle pulse per completed frame
//   rx_parity_err  parity mismatch on the completed frame (qualified by rx_valid)
//   rx_frame_err   stop bit sampled low (qualified by rx_valid)
module uart_device_core #(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_parity_err,
    output logic                  rx_frame_err
);

`ifdef UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] DIV_FULL  = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic             ODD       = 1'(PARITY_ODD);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;

    // ---------------- transmitter ----------------
    state_t                  tx_state_q, tx_state_d;
    logic [CNT_W-1:0]        tx_cnt_q, tx_cnt_d;
    logic [IDX_W-1:0]        tx_idx_q, tx_idx_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic                    tx_par_q, tx_par_d;
    logic                    tx_stop_q, tx_stop_d;
    logic                    tx_line_q, tx_line_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= StIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_stop_q  <= 1'b0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_stop_q  <= tx_stop_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // The accept edge only arms START; the line drops one edge later, so START runs
    // CLK_DIV+1 cycles while every later bit changes the line on its own state edge.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_stop_d  = tx_stop_q;
        tx_line_d  = tx_line_q;
        case (tx_state_q)
            StIdle: begin
                if (tx_valid) begin
                    tx_state_d = StStart;
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_data;
                    tx_par_d   = (^tx_data) ^ ODD;
                end
            end
            StStart: begin
                if (tx_cnt_q == DIV_FULL) begin
                    tx_state_d = StData;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_line_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d  = tx_cnt_q + 1'b1;
                    tx_line_d = 1'b0;
                end
            end
            StData: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IDX_LAST) begin
                        if (PAR_EN) begin
                            tx_state_d = StParity;
                            tx_line_d  = tx_par_q;
                        end else begin
                            tx_state_d = StStop;
                            tx_stop_d  = 1'b0;
                            tx_line_d  = 1'b1;
                        end
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = StStop;
                    tx_stop_d  = 1'b0;
                    tx_line_d  = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (tx_cnt_q == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_stop_q == STOP_LAST) begin
                        tx_state_d = StIdle;
                    end else begin
                        tx_stop_d = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    assign tx_ready = (tx_state_q == StIdle);
    assign tx       = tx_line_q;

    // ---------------- receiver ----------------
    logic [1:0]              sync_q;
    logic                    rx_s;
    state_t                  rx_state_q, rx_state_d;
    logic [CNT_W-1:0]        rx_cnt_q, rx_cnt_d;
    logic [IDX_W-1:0]        rx_idx_q, rx_idx_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic                    rx_par_q, rx_par_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_perr_q, rx_perr_d;
    logic                    rx_ferr_q, rx_ferr_d;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            rx_state_q <= StIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        case (rx_state_q)
            StIdle: begin
                if (!rx_s) begin
                    rx_state_d = StStart;
                    rx_cnt_d   = '0;
                end
            end
            StStart: begin
                // Half a bit in: a line that is high again was only a glitch.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StData: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_idx_q == IDX_LAST) begin
                        rx_state_d = PAR_EN ? StParity : StStop;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StParity: begin
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_s;
                    rx_state_d = StStop;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            StStop: begin
                // Back to IDLE right at the stop midpoint so the next start can be caught early.
                if (rx_cnt_q == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = StIdle;
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    rx_ferr_d  = ~rx_s;
                    rx_perr_d  = PAR_EN & (rx_par_q != ((^rx_shift_q) ^ ODD));
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_q;
    assign rx_frame_err  = rx_ferr_q;

endmodule

// File: tb/tb_uart_device_core.sv
// Scoreboard bench for uart_device_core: two instances, device A's rx selectable between
// device B's tx, its own tx (loopback) or a bench-driven line; device B's rx is A's tx.
module tb_uart_device_core;

    localparam int D  = 16;
    localparam int W  = 8;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FB = 1 + W + PB + 1;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk, rst;
    logic [7:0] a_tx_data, b_tx_data, a_rx_data, b_rx_data;
    logic       a_tx_valid, b_tx_valid, a_tx_ready, b_tx_ready, a_tx, b_tx, a_rx, b_rx;
    logic       a_rx_valid, b_rx_valid, a_perr, b_perr, a_ferr, b_ferr;
    logic       drv_rx, drv_sel, loop_sel;

    exp_t qa[$];
    exp_t qb[$];
    int   n_checks, n_fail;
    int   a_cnt, b_cnt;

    assign a_rx = drv_sel ? drv_rx : (loop_sel ? a_tx : b_tx);
    assign b_rx = a_tx;

    uart_device_core dut_a (
        .clk(clk), .rst(rst), .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx(a_tx), .rx(a_rx), .rx_data(a_rx_data), .rx_valid(a_rx_valid),
        .rx_parity_err(a_perr), .rx_frame_err(a_ferr)
    );

    uart_device_core dut_b (
        .clk(clk), .rst(rst), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx(b_tx), .rx(b_rx), .rx_data(b_rx_data), .rx_valid(b_rx_valid),
        .rx_parity_err(b_perr), .rx_frame_err(b_ferr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever either receiver presents a frame.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (a_rx_valid === 1'b1) begin
                a_cnt++;
                if (qa.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL a_unexpected_rx: got rx_valid with data %0h, expected none",
                             a_rx_data);
                end else begin
                    e = qa.pop_front();
                    check("a_rx_data", a_rx_data, e.data);
                    check("a_rx_parity_err", a_perr, e.perr);
                    check("a_rx_frame_err", a_ferr, e.ferr);
                end
            end
            if (b_rx_valid === 1'b1) begin
                b_cnt++;
                if (qb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL b_unexpected_rx: got rx_valid with data %0h, expected none",
                             b_rx_data);
                end else begin
                    e = qb.pop_front();
                    check("b_rx_data", b_rx_data, e.data);
                    check("b_rx_parity_err", b_perr, e.perr);
                    check("b_rx_frame_err", b_ferr, e.ferr);
                end
            end
        end
    end

    // Returns just after the accepting edge.
    task automatic send(input bit which, input logic [7:0] d, input bit expect_rx);
        int t;
        t = 0;
        @(negedge clk);
        while (((which == 1'b0) ? a_tx_ready : b_tx_ready) !== 1'b1 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_ready_timeout: tx_ready low for %0d cycles, expected high", t);
            return;
        end
        if (which == 1'b0) begin
            a_tx_data  = d;
            a_tx_valid = 1'b1;
        end else begin
            b_tx_data  = d;
            b_tx_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (which == 1'b0) begin
            a_tx_valid = 1'b0;
            a_tx_data  = ~d;
            if (expect_rx) begin
                qb.push_back('{data: d, perr: 1'b0, ferr: 1'b0});
                if (loop_sel && !drv_sel) qa.push_back('{data: d, perr: 1'b0, ferr: 1'b0});
            end
        end else begin
            b_tx_valid = 1'b0;
            b_tx_data  = ~d;
            if (expect_rx && !loop_sel && !drv_sel) qa.push_back('{data: d, perr: 1'b0, ferr: 1'b0});
        end
    endtask

    // Bench-driven frame into device A; a low stop bit is released early so the tail is idle.
    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop,
                               input logic perr_exp, input logic ferr_exp);
        qa.push_back('{data: d, perr: perr_exp, ferr: ferr_exp});
        @(negedge clk);
        drv_rx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < W; i++) begin
            drv_rx = d[i];
            repeat (D) @(negedge clk);
        end
        if (PB == 1) begin
            drv_rx = par;
            repeat (D) @(negedge clk);
        end
        drv_rx = stop;
        if (stop == 1'b0) begin
            repeat (D / 2 + 4) @(negedge clk);
            drv_rx = 1'b1;
            repeat (D / 2 - 4) @(negedge clk);
        end else begin
            repeat (D) @(negedge clk);
        end
        drv_rx = 1'b1;
        repeat (D) @(negedge clk);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d/%0d frames still pending, expected 0/0",
                     qa.size(), qb.size());
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        logic [FB-1:0] tx_exp;
        int            cnt0;
        n_checks   = 0;
        n_fail     = 0;
        a_cnt      = 0;
        b_cnt      = 0;
        rst        = 1'b1;
        a_tx_data  = 8'h00;
        b_tx_data  = 8'h00;
        a_tx_valid = 1'b0;
        b_tx_valid = 1'b0;
        drv_rx     = 1'b1;
        drv_sel    = 1'b0;
        loop_sel   = 1'b0;
`ifdef UART_PARITY_EN
        tx_exp = 11'b10101001010;
`else
        tx_exp = 10'b1101001010;
`endif

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", a_tx, 1'b1);
        check("reset_tx_ready", a_tx_ready, 1'b1);
        check("reset_rx_valid", a_rx_valid, 1'b0);
        check("reset_rx_data", a_rx_data, 8'h00);
        check("reset_parity_err", a_perr, 1'b0);
        check("reset_frame_err", a_ferr, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // TX frame 0xA5: bit midpoints, then ready timing.
        send(1'b0, 8'hA5, 1'b1);
        check("tx_ready_drop", a_tx_ready, 1'b0);
        repeat (1 + D / 2) @(posedge clk);
        #1;
        check("tx_bit", a_tx, tx_exp[0]);
        for (int i = 1; i < FB; i++) begin
            repeat (D) @(posedge clk);
            #1;
            check($sformatf("tx_bit%0d", i), a_tx, tx_exp[i]);
        end
        repeat (D / 2 - 1) @(posedge clk);
        #1;
        check("tx_ready_before_end", a_tx_ready, 1'b0);
        @(posedge clk);
        #1;
        check("tx_ready_at_end", a_tx_ready, 1'b1);
        wait_drain();

        // Reset mid-frame, with a handshake offered while reset is high.
        cnt0 = b_cnt;
        send(1'b0, 8'h5A, 1'b0);
        repeat (40) @(negedge clk);
        rst        = 1'b1;
        a_tx_valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tx_next_edge", a_tx, 1'b1);
        repeat (2) @(negedge clk);
        a_tx_valid = 1'b0;
        rst        = 1'b0;
        @(posedge clk);
        #1;
        check("rst_tx_after", a_tx, 1'b1);
        check("rst_tx_ready_after", a_tx_ready, 1'b1);
        repeat (2 * FB * D) @(posedge clk);
        check("rst_no_rx_valid", b_cnt, cnt0);

        // Loopback, back-to-back frames; B sees the same line.
        loop_sel = 1'b1;
        send(1'b0, 8'h00, 1'b1);
        send(1'b0, 8'hFF, 1'b1);
        send(1'b0, 8'h3C, 1'b1);
        wait_drain();
        loop_sel = 1'b0;

        // Glitch, framing and parity on a bench-driven line.
        drv_sel = 1'b1;
        repeat (4) @(negedge clk);
        cnt0 = a_cnt;
        drv_rx = 1'b0;
        repeat (3) @(negedge clk);
        drv_rx = 1'b1;
        repeat (3 * D) @(negedge clk);
        check("glitch_no_rx_valid", a_cnt, cnt0);
        drive_frame(8'h96, 1'b0, 1'b1, 1'b0, 1'b0);
        drive_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        drive_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef UART_PARITY_EN
        drive_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0);
        drive_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        wait_drain();
        drv_sel = 1'b0;
        repeat (4) @(negedge clk);

        // Full duplex between the cross-connected pair.
        fork
            send(1'b0, 8'h55, 1'b1);
            send(1'b1, 8'hAA, 1'b1);
        join
        wait_drain();
        check("final_a_frames", a_cnt, 4 + 3 + 2 * PB);
        check("final_b_frames", b_cnt, 1 + 3 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
